gru_gate_mac: RTL and testbench



---
 rtl/gru_gate_mac.sv | 140 ++++++++++++++
 tb/tb_gru_gate_mac.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gru_gate_mac.sv
// GRU gate pre-activation MAC: streams x and three gate weights per beat and
// accumulates r/z/n dot products plus bias in Q8.24, saturating at the output.
module gru_gate_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int QUAN       = 24,
  parameter int ACC_WIDTH  = 48,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [DATA_WIDTH-1:0] bias_r,
  input  logic [DATA_WIDTH-1:0] bias_z,
  input  logic [DATA_WIDTH-1:0] bias_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_wr,
  input  logic [DATA_WIDTH-1:0] in_wz,
  input  logic [DATA_WIDTH-1:0] in_wn,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic [DATA_WIDTH-1:0] out_n
);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, OUT} state_t;

  state_t state, state_nx;

  logic signed [ACC_WIDTH-1:0] acc_r, acc_z, acc_n;
  logic signed [ACC_WIDTH-1:0] prod_r, prod_z, prod_n;
  logic signed [ACC_WIDTH-1:0] sum_r, sum_z, sum_n;
  logic                        prod_valid;
  logic [LEN_WIDTH-1:0]        len_q, cnt;
  logic                        beat, last_beat;

  // Full-width signed product, floored to Q.QUAN and narrowed to the accumulator.
  function automatic logic signed [ACC_WIDTH-1:0] scale_prod(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = a * b;
    p = p >>> QUAN;
    return p[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-DATA_WIDTH:0] top;
    top = a[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((&top) || (~|top)) return a[DATA_WIDTH-1:0];
    else if (a[ACC_WIDTH-1]) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  assign in_ready  = (state == ACC);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt == len_q - LEN_WIDTH'(1));

  assign sum_r = acc_r + (prod_valid ? prod_r : '0);
  assign sum_z = acc_z + (prod_valid ? prod_z : '0);
  assign sum_n = acc_n + (prod_valid ? prod_n : '0);

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (vec_len == '0) ? OUT : ACC;
      ACC:     if (last_beat) state_nx = FLUSH;
      FLUSH:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_r      <= '0;
      acc_z      <= '0;
      acc_n      <= '0;
      prod_r     <= '0;
      prod_z     <= '0;
      prod_n     <= '0;
      prod_valid <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      out_r      <= '0;
      out_z      <= '0;
      out_n      <= '0;
    end else begin
      state      <= state_nx;
      prod_valid <= beat;

      if (beat) begin
        prod_r <= scale_prod(in_x, in_wr);
        prod_z <= scale_prod(in_x, in_wz);
        prod_n <= scale_prod(in_x, in_wn);
        cnt    <= cnt + LEN_WIDTH'(1);
      end

      if (state == IDLE && start) begin
        acc_r <= sext(bias_r);
        acc_z <= sext(bias_z);
        acc_n <= sext(bias_n);
        cnt   <= '0;
        len_q <= vec_len;
        // An empty vector is just the bias, which always fits the output range.
        if (vec_len == '0) begin
          out_r <= bias_r;
          out_z <= bias_z;
          out_n <= bias_n;
        end
      end else begin
        acc_r <= sum_r;
        acc_z <= sum_z;
        acc_n <= sum_n;
      end

      if (state == FLUSH) begin
        out_r <= sat(sum_r);
        out_z <= sat(sum_z);
        out_n <= sat(sum_n);
      end
    end
  end

endmodule

// File: tb/tb_gru_gate_mac.sv
// Scoreboard bench for gru_gate_mac: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_gru_gate_mac;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] z;
    logic [31:0] n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  vec_len;
  logic [31:0] bias_r, bias_z, bias_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_wr, in_wz, in_wn;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r, out_z, out_n;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] bx[4], bwr[4], bwz[4], bwn[4];

  gru_gate_mac dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .bias_r(bias_r), .bias_z(bias_z), .bias_n(bias_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_wr(in_wr), .in_wz(in_wz), .in_wn(in_wn),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_z(out_z), .out_n(out_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got r=%h z=%h n=%h, expected none", out_r, out_z, out_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_r", out_r, e.r);
        check("out_z", out_z, e.z);
        check("out_n", out_n, e.n);
      end
    end
  end

  task automatic set_beat(input int i, input logic [31:0] x, wr, wz, wn);
    bx[i] = x; bwr[i] = wr; bwz[i] = wz; bwn[i] = wn;
  endtask

  task automatic start_job(input logic [9:0] len, input logic [31:0] br, bz, bn);
    start = 1'b1; vec_len = len; bias_r = br; bias_z = bz; bias_n = bn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] x, wr, wz, wn);
    bit got = 0;
    in_valid = 1'b1; in_x = x; in_wr = wr; in_wz = wz; in_wn = wn;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) check("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got = 1; break; end
    end
    if (!got) check("out_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int len, input logic [31:0] br, bz, bn,
                         input int gap, input bit pulse, input exp_t e);
    sb.push_back(e);
    start_job(10'(len), br, bz, bn);
    for (int i = 0; i < len; i++) begin
      send_beat(bx[i], bwr[i], bwz[i], bwn[i]);
      if (i < len - 1) begin
        repeat (gap) begin
          if (pulse) begin start = 1'b1; vec_len = 10'd0; bias_r = 32'hDEAD_BEEF; end
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vec_len = '0;
    bias_r = '0; bias_z = '0; bias_n = '0;
    in_valid = 1'b0; in_x = '0; in_wr = '0; in_wz = '0; in_wn = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_r", out_r, 32'd0);
    check("rst_out_z", out_z, 32'd0);
    check("rst_out_n", out_n, 32'd0);
    rst = 1'b0;

    // Beats offered in IDLE must not be taken.
    in_valid = 1'b1; in_x = 32'h0500_0000; in_wr = 32'h0500_0000;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 1.0*0.5 + 0.25 = 0.75 on every gate, with latency checks.
    sb.push_back('{32'h00C0_0000, 32'h00C0_0000, 32'h00C0_0000});
    start_job(10'd1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000);
    in_valid = 1'b1; in_x = 32'h0100_0000;
    in_wr = 32'h0080_0000; in_wz = 32'h0080_0000; in_wn = 32'h0080_0000;
    @(negedge clk);
    check("acc_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_l1_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_l2_out_valid", {31'd0, out_valid}, 32'd1);
    wait_done();

    // x = (1, 2, -1): r = 0.5*2 = 1.0, z = 1.0*2 = 2.0, n = -0.25*2 = -0.5.
    set_beat(0, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 32'hFFC0_0000);
    set_beat(1, 32'h0200_0000, 32'h0080_0000, 32'h0100_0000, 32'hFFC0_0000);
    set_beat(2, 32'hFF00_0000, 32'h0080_0000, 32'h0100_0000, 32'hFFC0_0000);
    run_job(3, 32'd0, 32'd0, 32'd0, 0, 1'b0, '{32'h0100_0000, 32'h0200_0000, 32'hFF80_0000});
    // Same vector with 2-cycle stalls and start pulses while accumulating.
    run_job(3, 32'd0, 32'd0, 32'd0, 2, 1'b1, '{32'h0100_0000, 32'h0200_0000, 32'hFF80_0000});

    // Floor: 2^-24 * -0.5 -> -2^-24; 2^-24 * 0.5 -> 0.
    set_beat(0, 32'h0000_0001, 32'hFF80_0000, 32'h0080_0000, 32'h0000_0000);
    run_job(1, 32'd0, 32'd0, 32'd0, 0, 1'b0, '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});

    // Saturation both ways.
    for (int i = 0; i < 4; i++)
      set_beat(i, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_job(4, 32'd0, 32'd0, 32'd0, 0, 1'b0, '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    for (int i = 0; i < 4; i++)
      set_beat(i, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_job(4, 32'd0, 32'd0, 32'd0, 0, 1'b0, '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000});

    // Empty vector: biases appear one cycle after start.
    sb.push_back('{32'h1234_5678, 32'hFEDC_BA98, 32'h0000_0001});
    start_job(10'd0, 32'h1234_5678, 32'hFEDC_BA98, 32'h0000_0001);
    check("len0_out_valid", {31'd0, out_valid}, 32'd1);
    check("len0_out_r", out_r, 32'h1234_5678);
    wait_done();

    // Back-pressure: 2.0 * (0.5, -1.0, 0.25) held for 5 cycles with start/beats offered.
    out_ready = 1'b0;
    sb.push_back('{32'h0100_0000, 32'hFE00_0000, 32'h0080_0000});
    start_job(10'd1, 32'd0, 32'd0, 32'd0);
    send_beat(32'h0200_0000, 32'h0080_0000, 32'hFF00_0000, 32'h0040_0000);
    begin
      bit got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid) begin got = 1; break; end
      end
      if (!got) check("hold_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    start = 1'b1; vec_len = 10'd0; bias_r = 32'h5555_5555;
    in_valid = 1'b1; in_x = 32'h0100_0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_r", out_r, 32'h0100_0000);
      check("hold_out_z", out_z, 32'hFE00_0000);
      check("hold_out_n", out_n, 32'h0080_0000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("handshake_out_valid", {31'd0, out_valid}, 32'd0);
    start = 1'b0; in_valid = 1'b0;

    // Reset after 2 of 4 beats, then a clean single-beat job.
    start_job(10'd4, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    send_beat(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    send_beat(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_out_r", out_r, 32'd0);
    check("abort_out_z", out_z, 32'd0);
    check("abort_out_n", out_n, 32'd0);
    set_beat(0, 32'h0100_0000, 32'h0040_0000, 32'h0080_0000, 32'hFF00_0000);
    run_job(1, 32'd0, 32'd0, 32'd0, 0, 1'b0, '{32'h0040_0000, 32'h0080_0000, 32'hFF00_0000});

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
